// File: rtl/heart_rate_calc_pkg.sv
// Shared types and constants for the heart-rate path.
// State encoding, display widths and the BPM numerator.
package heart_rate_calc_pkg;

  typedef enum logic [1:0] {
    WAIT_FIRST,
    TIMING,
    DIVIDE
  } hr_state_e;

  localparam int BPM_W = 8;
  localparam int REJ_W = 8;

  localparam int DEF_FS_HZ     = 250;
  localparam int DEF_AVG_DEPTH = 4;

  function automatic int calc_num(input int fs, input int depth);
    return 60 * fs * depth;
  endfunction

  function automatic int calc_num_w(input int num);
    return $clog2(num + 1);
  endfunction

  localparam int NUM   = calc_num(DEF_FS_HZ, DEF_AVG_DEPTH);
  localparam int NUM_W = calc_num_w(NUM);

endpackage

// File: rtl/heart_rate_calc_if.sv
// Peak-in / rate-out bundle between detector, calculator
// and display path.
interface heart_rate_calc_if;
  import heart_rate_calc_pkg::*;

  logic             sample_tick;
  logic             peak;
  logic [BPM_W-1:0] bpm;
  logic             bpm_valid;
  logic             beat;
  logic [REJ_W-1:0] reject_cnt;

  modport master (
    output sample_tick,
    output peak,
    input  bpm,
    input  bpm_valid,
    input  beat,
    input  reject_cnt
  );

  modport slave (
    input  sample_tick,
    input  peak,
    output bpm,
    output bpm_valid,
    output beat,
    output reject_cnt
  );

endinterface

// File: rtl/heart_rate_calc_seq_divider.sv
// Unsigned restoring divider: one load cycle, then one
// quotient bit per cycle, MSB first.
module seq_divider #(
  parameter int DW = 16,
  parameter int VW = 14
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          abort_i,
  input  logic          start_i,
  input  logic [DW-1:0] dividend_i,
  input  logic [VW-1:0] divisor_i,
  output logic          busy_o,
  output logic          done_o,
  output logic [DW-1:0] quotient_o
);

  localparam int CW = $clog2(DW);

  logic          busy_q;
  logic [CW-1:0] cnt_q;
  logic [VW-1:0] rem_q;
  logic [VW-1:0] dvs_q;
  logic [DW-1:0] quo_q;

  logic [VW:0]   trial;
  logic [VW:0]   diff;
  logic          ge;
  logic [VW-1:0] rem_d;
  logic [DW-1:0] quo_d;

  // trial < 2*divisor, so the borrow bit alone decides the subtract
  always_comb begin
    trial = {rem_q, quo_q[DW-1]};
    diff  = trial - {1'b0, dvs_q};
    ge    = ~diff[VW];
    rem_d = ge ? diff[VW-1:0] : trial[VW-1:0];
    quo_d = {quo_q[DW-2:0], ge};
  end

  assign busy_o     = busy_q;
  assign done_o     = busy_q && (cnt_q == CW'(DW - 1));
  assign quotient_o = quo_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      quo_q  <= '0;
    end else if (abort_i) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      cnt_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= divisor_i;
      quo_q  <= dividend_i;
    end else if (busy_q) begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      cnt_q <= cnt_q + 1'b1;
      if (done_o) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/heart_rate_calc.sv
// Inter-beat interval timer, rolling average and BPM
// conversion feeding the display path.
module heart_rate_calc
  import heart_rate_calc_pkg::*;
#(
  parameter int FS_HZ     = 250,
  parameter int MIN_IBI   = 75,
  parameter int MAX_IBI   = 500,
  parameter int AVG_DEPTH = 4,
  parameter int IBI_W     = 12
) (
  input  logic             clk,
  input  logic             reset,
  heart_rate_calc_if.slave hr
);

  localparam int PW     = $clog2(AVG_DEPTH);
  localparam int SUM_W  = IBI_W + PW;
  localparam int FILL_W = $clog2(AVG_DEPTH + 1);
  localparam int NUM_V  = calc_num(FS_HZ, AVG_DEPTH);
  localparam int NUM_WV = calc_num_w(NUM_V);

  localparam logic [IBI_W-1:0]  MIN_C  = IBI_W'(MIN_IBI);
  localparam logic [IBI_W-1:0]  MAX_C  = IBI_W'(MAX_IBI);
  localparam logic [FILL_W-1:0] FULL   = FILL_W'(AVG_DEPTH);
  localparam logic [FILL_W-1:0] FULL_M = FILL_W'(AVG_DEPTH - 1);

  hr_state_e          state_q, state_d;
  logic [IBI_W-1:0]   cnt_q, cnt_d;
  logic [IBI_W-1:0]   ring_q [AVG_DEPTH];
  logic [PW-1:0]      wptr_q;
  logic [SUM_W-1:0]   sum_q, sum_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic [IBI_W-1:0]   pend_q;
  logic               pend_vld_q, pend_vld_d;
  logic [BPM_W-1:0]   bpm_q;
  logic               valid_q;
  logic               beat_q;
  logic [REJ_W-1:0]   rej_q;

  logic               timeout;
  logic               accept;
  logic               early;
  logic               store;
  logic               done_ok;
  logic               commit_pend;
  logic               commit_new;
  logic               commit;
  logic               to_pend;
  logic               div_start;
  logic [IBI_W-1:0]   wval;
  logic               div_busy;
  logic               div_done;
  logic [NUM_WV-1:0]  div_quo;
  logic [BPM_W-1:0]   bpm_sat;

  assign timeout = (state_q != WAIT_FIRST) && (cnt_q >= MAX_C);

  assign accept = hr.peak && !timeout &&
                  ((state_q == WAIT_FIRST) || (cnt_q >= MIN_C));

  assign early = hr.peak && !timeout &&
                 (state_q != WAIT_FIRST) && (cnt_q < MIN_C);

  assign store   = accept && (state_q != WAIT_FIRST);
  assign done_ok = div_done && !timeout;

  // An interval goes straight into the ring only when the
  // divider is free; otherwise it parks in the pending slot.
  assign commit_pend = done_ok && pend_vld_q;
  assign commit_new  = store &&
                       (!div_busy || (done_ok && !pend_vld_q));
  assign to_pend     = store && !commit_new;
  assign commit      = commit_pend || commit_new;
  assign wval        = commit_pend ? pend_q : cnt_q;
  assign div_start   = commit && (fill_q >= FULL_M);

  assign bpm_sat = (|div_quo[NUM_WV-1:BPM_W]) ? '1
                 : div_quo[BPM_W-1:0];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sum_d      = sum_q;
    fill_d     = fill_q;
    pend_vld_d = pend_vld_q;

    if (timeout) begin
      cnt_d = '0;
    end else if (accept) begin
      cnt_d = IBI_W'(hr.sample_tick);
    end else if ((state_q != WAIT_FIRST) && hr.sample_tick) begin
      cnt_d = cnt_q + 1'b1;
    end

    if (timeout) begin
      sum_d  = '0;
      fill_d = '0;
    end else if (commit) begin
      sum_d = sum_q + SUM_W'(wval) - SUM_W'(ring_q[wptr_q]);
      if (fill_q != FULL) fill_d = fill_q + 1'b1;
    end

    if (timeout)          pend_vld_d = 1'b0;
    else if (to_pend)     pend_vld_d = 1'b1;
    else if (commit_pend) pend_vld_d = 1'b0;

    unique case (state_q)
      WAIT_FIRST: begin
        if (hr.peak) state_d = TIMING;
      end
      TIMING: begin
        if (timeout)        state_d = WAIT_FIRST;
        else if (div_start) state_d = DIVIDE;
      end
      DIVIDE: begin
        if (timeout)      state_d = WAIT_FIRST;
        else if (done_ok) state_d = div_start ? DIVIDE : TIMING;
      end
      default: state_d = WAIT_FIRST;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= WAIT_FIRST;
      cnt_q      <= '0;
      wptr_q     <= '0;
      sum_q      <= '0;
      fill_q     <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      bpm_q      <= '0;
      valid_q    <= 1'b0;
      beat_q     <= 1'b0;
      rej_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sum_q      <= sum_d;
      fill_q     <= fill_d;
      pend_vld_q <= pend_vld_d;
      beat_q     <= accept;
      if (early && (rej_q != '1)) rej_q <= rej_q + 1'b1;
      if (to_pend) pend_q <= cnt_q;
      // bpm holds its last reading across a signal loss
      if (timeout) begin
        wptr_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        if (commit) wptr_q <= wptr_q + 1'b1;
        if (done_ok) begin
          bpm_q   <= bpm_sat;
          valid_q <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < AVG_DEPTH; i++) ring_q[i] <= '0;
    end else begin
      for (int i = 0; i < AVG_DEPTH; i++) begin
        if (timeout)
          ring_q[i] <= '0;
        else if (commit && (wptr_q == PW'(i)))
          ring_q[i] <= wval;
      end
    end
  end

  seq_divider #(
    .DW (NUM_WV),
    .VW (SUM_W)
  ) u_div (
    .clk        (clk),
    .rst_n      (reset),
    .abort_i    (timeout),
    .start_i    (div_start),
    .dividend_i (NUM_WV'(NUM_V)),
    .divisor_i  (sum_d),
    .busy_o     (div_busy),
    .done_o     (div_done),
    .quotient_o (div_quo)
  );

  assign hr.bpm        = bpm_q;
  assign hr.bpm_valid  = valid_q;
  assign hr.beat       = beat_q;
  assign hr.reject_cnt = rej_q;

endmodule
